// File: rtl/mi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mi_arb_pkg
// Brief    : Shared constants and FSM state encoding for the two-requester
//            mi_* burst arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mi_arb_pkg;

    localparam int MI_LEN_W  = 7;
    localparam int MI_DATA_W = 32;

    // Arbiter FSM: wait for a request, present the command, route beats
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } mi_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mi_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : mi_arb_pick
// Brief    : Combinational two-input picker. When both inputs request, the
//            port named by rr wins; a lone requester always wins.
// Revision : 1.0 - initial release
// ============================================================================
module mi_arb_pick (
    input  logic [1:0] req,
    input  logic       rr,
    output logic       gnt,
    output logic       any
);

    // Preferred port on contention, otherwise whichever port is asking
    always_comb begin
        any = |req;
        gnt = 1'b0;
        if (&req) begin
            gnt = rr;
        end else begin
            gnt = req[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mi_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mi_burst_arbiter
// Brief    : Two-requester arbiter in front of the mi_* burst slave. Grants
//            one master per burst, forwards its command, and routes the
//            downstream write/read strobes to it until the last beat.
//            Define MI_ARB_ROUND_ROBIN_EN for round-robin arbitration;
//            otherwise port 0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module mi_burst_arbiter
    import mi_arb_pkg::*;
#(
    parameter int AW = 20
) (
    input  logic                 clk,
    input  logic                 rst,

    // Requester 0
    input  logic [AW-1:0]        m0_addr,
    input  logic [MI_LEN_W-1:0]  m0_len,
    input  logic                 m0_rw,
    input  logic                 m0_valid,
    output logic                 m0_ready,
    input  logic [MI_DATA_W-1:0] m0_wdata,
    output logic                 m0_wack,
    output logic                 m0_wlast,
    output logic [MI_DATA_W-1:0] m0_rdata,
    output logic                 m0_rstb,
    output logic                 m0_rlast,

    // Requester 1
    input  logic [AW-1:0]        m1_addr,
    input  logic [MI_LEN_W-1:0]  m1_len,
    input  logic                 m1_rw,
    input  logic                 m1_valid,
    output logic                 m1_ready,
    input  logic [MI_DATA_W-1:0] m1_wdata,
    output logic                 m1_wack,
    output logic                 m1_wlast,
    output logic [MI_DATA_W-1:0] m1_rdata,
    output logic                 m1_rstb,
    output logic                 m1_rlast,

    // Downstream burst slave
    output logic [AW-1:0]        s_addr,
    output logic [MI_LEN_W-1:0]  s_len,
    output logic                 s_rw,
    output logic                 s_valid,
    input  logic                 s_ready,
    output logic [MI_DATA_W-1:0] s_wdata,
    input  logic                 s_wack,
    input  logic                 s_wlast,
    input  logic [MI_DATA_W-1:0] s_rdata,
    input  logic                 s_rstb,
    input  logic                 s_rlast
);

    mi_arb_state_t         r_state;
    mi_arb_state_t         w_state_nxt;
    logic                  r_gnt;
    logic                  w_pick_gnt;
    logic                  w_any;
    logic                  w_rr;
    logic                  w_burst_end;

    // Granted requester's command and write data
    logic                  w_sel_valid;
    logic [AW-1:0]         w_sel_addr;
    logic [MI_LEN_W-1:0]   w_sel_len;
    logic                  w_sel_rw;
    logic [MI_DATA_W-1:0]  w_sel_wdata;

    assign w_sel_valid = r_gnt ? m1_valid : m0_valid;
    assign w_sel_addr  = r_gnt ? m1_addr  : m0_addr;
    assign w_sel_len   = r_gnt ? m1_len   : m0_len;
    assign w_sel_rw    = r_gnt ? m1_rw    : m0_rw;
    assign w_sel_wdata = r_gnt ? m1_wdata : m0_wdata;

    // Bursts end only on the downstream last strobe; no beat counting here
    assign w_burst_end = (r_state == DATA) && (s_rlast || s_wlast);

    mi_arb_pick u_pick (
        .req (({m1_valid, m0_valid})),
        .rr  (w_rr),
        .gnt (w_pick_gnt),
        .any (w_any)
    );

`ifdef MI_ARB_ROUND_ROBIN_EN
    logic r_rr;

    // Prefer the other port once a burst completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr <= 1'b0;
        end else if (w_burst_end) begin
            r_rr <= ~r_gnt;
        end
    end

    assign w_rr = r_rr;
`else
    // Fixed priority: port 0 wins every contention
    assign w_rr = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant pointer is captured only while arbitrating in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt <= 1'b0;
        end else if ((r_state == IDLE) && w_any) begin
            r_gnt <= w_pick_gnt;
        end
    end

    // Next state and all outputs; everything is zero outside its phase
    always_comb begin
        w_state_nxt = r_state;
        s_valid     = 1'b0;
        s_addr      = '0;
        s_len       = '0;
        s_rw        = 1'b0;
        s_wdata     = '0;
        m0_ready    = 1'b0;
        m0_wack     = 1'b0;
        m0_wlast    = 1'b0;
        m0_rstb     = 1'b0;
        m0_rlast    = 1'b0;
        m0_rdata    = '0;
        m1_ready    = 1'b0;
        m1_wack     = 1'b0;
        m1_wlast    = 1'b0;
        m1_rstb     = 1'b0;
        m1_rlast    = 1'b0;
        m1_rdata    = '0;

        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = CMD;
                end
            end

            CMD: begin
                s_valid = w_sel_valid;
                s_addr  = w_sel_addr;
                s_len   = w_sel_len;
                s_rw    = w_sel_rw;
                if (w_sel_valid && s_ready) begin
                    m0_ready    = ~r_gnt;
                    m1_ready    = r_gnt;
                    w_state_nxt = DATA;
                end else if (!w_sel_valid) begin
                    // Withdrawn request: re-arbitrate, pointer untouched
                    w_state_nxt = IDLE;
                end
            end

            DATA: begin
                s_wdata  = w_sel_wdata;
                m0_rdata = s_rdata;
                m1_rdata = s_rdata;
                if (r_gnt) begin
                    m1_wack  = s_wack;
                    m1_wlast = s_wlast;
                    m1_rstb  = s_rstb;
                    m1_rlast = s_rlast;
                end else begin
                    m0_wack  = s_wack;
                    m0_wlast = s_wlast;
                    m0_rstb  = s_rstb;
                    m0_rlast = s_rlast;
                end
                if (w_burst_end) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
